// File: rtl/vc_pop_arbiter_pkg.sv
// rtl/vc_pop_arbiter_pkg.sv - shared state encodings, class tags and width defaults for the VC pop arbiter
package vc_pop_arbiter_pkg;

    localparam int MAIN_SIZE_DEFAULT = 8;
    localparam int DATA_SIZE_DEFAULT = MAIN_SIZE_DEFAULT + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] TAG_FIFO0 = 2'b00;
    localparam logic [1:0] TAG_FIFO1 = 2'b10;

endpackage

// File: rtl/vc_pop_arbiter_wrr_grant_counter.sv
// rtl/vc_pop_arbiter_wrr_grant_counter.sv - per-turn grant counter and weight compare for the WRR arbiter
module wrr_grant_counter #(
    parameter int WEIGHT0 = 3,
    parameter int WEIGHT1 = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    input  logic sel_i,
    output logic turn_done_o
);

    localparam logic [3:0] LAST0 = 4'(WEIGHT0 - 1);
    localparam logic [3:0] LAST1 = 4'(WEIGHT1 - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // A new turn always starts from zero, even if the entering cycle also pops.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 4'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign turn_done_o = inc_i && (cnt_q == (sel_i ? LAST1 : LAST0));

endmodule

// File: rtl/vc_pop_arbiter.sv
// rtl/vc_pop_arbiter.sv - drains two class FIFOs into one tagged egress lane by weighted round-robin
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
    parameter int MAIN_SIZE = MAIN_SIZE_DEFAULT,
    parameter int WEIGHT0   = 3,
    parameter int WEIGHT1   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo0_empty,
    input  logic                 fifo1_empty,
    input  logic                 fifo0_almost_full,
    input  logic                 fifo1_almost_full,
    input  logic [MAIN_SIZE-1:0] fifo0_data,
    input  logic [MAIN_SIZE-1:0] fifo1_data,
    input  logic                 dest_ready,
    output logic                 pop0,
    output logic                 pop1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic                 push_pause,
    output logic                 grant_id
);

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic                 rr_ptr_q;
    logic                 rr_ptr_d;
    logic                 pop_d1_q;
    logic                 sel_d1_q;
    logic                 valid_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 push_pause_q;
    logic                 grant_id_q;

    logic in_serve0;
    logic in_serve1;
    logic cur_empty;
    logic other_empty;
    logic turn_done;
    logic leave;
    logic cnt_clear;

    assign in_serve0   = (state_q == SERVE0);
    assign in_serve1   = (state_q == SERVE1);
    assign cur_empty   = in_serve1 ? fifo1_empty : fifo0_empty;
    assign other_empty = in_serve1 ? fifo0_empty : fifo1_empty;

    assign pop0 = ~reset & in_serve0 & ~fifo0_empty & dest_ready;
    assign pop1 = ~reset & in_serve1 & ~fifo1_empty & dest_ready;

    // With dest_ready low the turn is frozen: no pop, no count, no hand-over.
    assign leave     = (in_serve0 | in_serve1) & dest_ready & (cur_empty | turn_done);
    assign cnt_clear = (state_d != IDLE) && (state_d != state_q);

    wrr_grant_counter #(
        .WEIGHT0 (WEIGHT0),
        .WEIGHT1 (WEIGHT1)
    ) u_grant_counter (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (cnt_clear),
        .inc_i       (pop0 | pop1),
        .sel_i       (in_serve1),
        .turn_done_o (turn_done)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (!fifo0_empty && !fifo1_empty) begin
                    state_d = rr_ptr_q ? SERVE1 : SERVE0;
                end else if (!fifo0_empty) begin
                    state_d = SERVE0;
                end else if (!fifo1_empty) begin
                    state_d = SERVE1;
                end
            end
            SERVE0, SERVE1: begin
                if (leave) begin
                    rr_ptr_d = in_serve0;
                    if (other_empty) begin
                        state_d = IDLE;
                    end else begin
                        state_d = in_serve0 ? SERVE1 : SERVE0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO read data lags the pop by one cycle, so the source is carried alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            pop_d1_q     <= 1'b0;
            sel_d1_q     <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            push_pause_q <= 1'b0;
            grant_id_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            pop_d1_q     <= pop0 | pop1;
            sel_d1_q     <= pop1;
            valid_q      <= pop_d1_q;
            if (pop_d1_q) begin
                data_q <= {(sel_d1_q ? TAG_FIFO1 : TAG_FIFO0),
                           (sel_d1_q ? fifo1_data : fifo0_data)};
            end
            push_pause_q <= fifo0_almost_full | fifo1_almost_full;
            grant_id_q   <= (state_d == SERVE1);
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign push_pause = push_pause_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb/tb_vc_pop_arbiter.sv - self-checking bench for vc_pop_arbiter with FIFO models and scoreboard
module tb_vc_pop_arbiter;
    import vc_pop_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo0_empty = 1'b1;
    logic       fifo1_empty = 1'b1;
    logic       fifo0_almost_full = 1'b0;
    logic       fifo1_almost_full = 1'b0;
    logic [7:0] fifo0_data = 8'h00;
    logic [7:0] fifo1_data = 8'h00;
    logic       dest_ready = 1'b0;
    logic       pop0;
    logic       pop1;
    logic [9:0] data_out;
    logic       valid_out;
    logic       push_pause;
    logic       grant_id;

    always #5 clk = ~clk;

    vc_pop_arbiter #(
        .DATA_SIZE (10),
        .MAIN_SIZE (8),
        .WEIGHT0   (3),
        .WEIGHT1   (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo0_empty       (fifo0_empty),
        .fifo1_empty       (fifo1_empty),
        .fifo0_almost_full (fifo0_almost_full),
        .fifo1_almost_full (fifo1_almost_full),
        .fifo0_data        (fifo0_data),
        .fifo1_data        (fifo1_data),
        .dest_ready        (dest_ready),
        .pop0              (pop0),
        .pop1              (pop1),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .push_pause        (push_pause),
        .grant_id          (grant_id)
    );

    typedef struct {
        int         n0;
        logic [7:0] d0 [8];
        int         n1;
        logic [7:0] d1 [4];
        int         ne;
        logic [9:0] e  [12];
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [9:0] exp_q [$];
    logic [9:0] rx_q [$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         first_pop = -1;
    int         first_valid = -1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // FIFO models: registered read data and empty flags, updated on the same edge as the DUT.
    always @(posedge clk) begin
        if (pop0) begin
            chk("pop0_not_empty", (q0.size() != 0), 1);
            if (q0.size() != 0) begin
                fifo0_data <= q0[0];
                exp_q.push_back({TAG_FIFO0, q0[0]});
                void'(q0.pop_front());
            end
            if (first_pop < 0) first_pop = cyc;
        end
        if (pop1) begin
            chk("pop1_not_empty", (q1.size() != 0), 1);
            if (q1.size() != 0) begin
                fifo1_data <= q1[0];
                exp_q.push_back({TAG_FIFO1, q1[0]});
                void'(q1.pop_front());
            end
            if (first_pop < 0) first_pop = cyc;
        end
        fifo0_empty <= (q0.size() == 0);
        fifo1_empty <= (q1.size() == 0);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        chk("pop_exclusive", (pop0 & pop1), 0);
        if (pop0 | pop1) chk("grant_id", grant_id, pop1);
        if (valid_out === 1'b1) begin
            if (first_valid < 0) first_valid = cyc;
            rx_q.push_back(data_out);
            if (exp_q.size() == 0) chk("extra_word", data_out, 32'hFFFF_FFFF);
            else chk("scoreboard", data_out, exp_q.pop_front());
        end
    end

    task automatic start_vector(input int k);
        @(posedge clk); #1;
        reset = 1'b1;
        dest_ready = 1'b1;
        fifo0_almost_full = 1'b1;
        fifo1_almost_full = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete(); rx_q.delete();
        for (int i = 0; i < vecs[k].n0; i++) q0.push_back(vecs[k].d0[i]);
        for (int i = 0; i < vecs[k].n1; i++) q1.push_back(vecs[k].d1[i]);
        first_pop = -1;
        first_valid = -1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_rst_pop0", k), pop0, 0);
            chk($sformatf("v%0d_rst_pop1", k), pop1, 0);
            chk($sformatf("v%0d_rst_valid", k), valid_out, 0);
            chk($sformatf("v%0d_rst_pause", k), push_pause, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        fifo0_almost_full = 1'b0;
        fifo1_almost_full = 1'b0;
    endtask

    task automatic finish_vector(input int k);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !pop0 && !pop1) done = 1'b1;
        end
        chk($sformatf("v%0d_drain_timeout", k), done, 1);
        chk($sformatf("v%0d_idle_after_drain", k), 32'(dut.state_q), 32'(IDLE));
        chk($sformatf("v%0d_latency", k), first_valid - first_pop, 2);
        chk($sformatf("v%0d_rx_count", k), rx_q.size(), vecs[k].ne);
        for (int i = 0; i < vecs[k].ne && i < rx_q.size(); i++)
            chk($sformatf("v%0d_word%0d", k, i), rx_q[i], vecs[k].e[i]);
    endtask

    initial begin
        int inflight;
        bit seen;

        vecs[0].n0 = 4; vecs[0].d0 = '{0: 8'hFF, 1: 8'hEE, 2: 8'hAA, 3: 8'hBB, default: 8'h00};
        vecs[0].n1 = 2; vecs[0].d1 = '{0: 8'hDD, 1: 8'hCC, default: 8'h00};
        vecs[0].ne = 6; vecs[0].e  = '{0: 10'h0FF, 1: 10'h0EE, 2: 10'h0AA, 3: 10'h2DD, 4: 10'h0BB, 5: 10'h2CC, default: 10'h000};
        vecs[1].n0 = 0; vecs[1].d0 = '{default: 8'h00};
        vecs[1].n1 = 3; vecs[1].d1 = '{0: 8'h99, 1: 8'h88, 2: 8'h77, default: 8'h00};
        vecs[1].ne = 3; vecs[1].e  = '{0: 10'h299, 1: 10'h288, 2: 10'h277, default: 10'h000};
        vecs[2].n0 = 4; vecs[2].d0 = '{0: 8'h51, 1: 8'h52, 2: 8'h53, 3: 8'h54, default: 8'h00};
        vecs[2].n1 = 0; vecs[2].d1 = '{default: 8'h00};
        vecs[2].ne = 4; vecs[2].e  = '{0: 10'h051, 1: 10'h052, 2: 10'h053, 3: 10'h054, default: 10'h000};
        vecs[3].n0 = 5; vecs[3].d0 = '{0: 8'h11, 1: 8'h22, 2: 8'h33, 3: 8'h44, 4: 8'h55, default: 8'h00};
        vecs[3].n1 = 3; vecs[3].d1 = '{0: 8'hA1, 1: 8'hA2, 2: 8'hA3, default: 8'h00};
        vecs[3].ne = 8; vecs[3].e  = '{0: 10'h011, 1: 10'h022, 2: 10'h033, 3: 10'h2A1, 4: 10'h044,
                                      5: 10'h055, 6: 10'h2A2, 7: 10'h2A3, default: 10'h000};
        vecs[4].n0 = 1; vecs[4].d0 = '{0: 8'h01, default: 8'h00};
        vecs[4].n1 = 3; vecs[4].d1 = '{0: 8'h02, 1: 8'h03, 2: 8'h04, default: 8'h00};
        vecs[4].ne = 4; vecs[4].e  = '{0: 10'h001, 1: 10'h202, 2: 10'h203, 3: 10'h204, default: 10'h000};
        vecs[5].n0 = 5; vecs[5].d0 = '{0: 8'h11, 1: 8'h12, 2: 8'h13, 3: 8'h14, 4: 8'h15, default: 8'h00};
        vecs[5].n1 = 2; vecs[5].d1 = '{0: 8'h21, 1: 8'h22, default: 8'h00};
        vecs[5].ne = 7; vecs[5].e  = '{0: 10'h011, 1: 10'h012, 2: 10'h013, 3: 10'h221, 4: 10'h014,
                                      5: 10'h015, 6: 10'h222, default: 10'h000};
        vecs[6].n0 = 5; vecs[6].d0 = '{0: 8'h31, 1: 8'h32, 2: 8'h33, 3: 8'h34, 4: 8'h35, default: 8'h00};
        vecs[6].n1 = 2; vecs[6].d1 = '{0: 8'h41, 1: 8'h42, default: 8'h00};
        vecs[6].ne = 6; vecs[6].e  = '{0: 10'h031, 1: 10'h033, 2: 10'h034, 3: 10'h035, 4: 10'h241,
                                      5: 10'h242, default: 10'h000};

        for (int k = 0; k < 5; k++) begin
            start_vector(k);
            finish_vector(k);
        end

        // Backpressure: dest_ready low for 4 cycles once two pops are in the pipe.
        start_vector(5);
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        dest_ready = 1'b0;
        inflight = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp_no_pop_c%0d", i), (pop0 | pop1), 0);
            if (valid_out) inflight++;
        end
        chk("bp_inflight_le2", (inflight <= 2), 1);
        @(posedge clk); #1;
        dest_ready = 1'b1;
        finish_vector(5);

        // Mid-stream reset while FIFO0 is being served.
        start_vector(6);
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        chk("mid_reset_in_serve0", 32'(dut.state_q), 32'(SERVE0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_reset_valid_low", valid_out, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (pop0 | pop1) begin
                seen = 1'b1;
                chk("mid_reset_restart_fifo0", pop0, 1);
            end else begin
                @(negedge clk);
            end
        end
        chk("mid_reset_pop_timeout", seen, 1);
        finish_vector(6);

        // push_pause follows either almost-full flag one cycle later.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            fifo1_almost_full = (i >= 1 && i <= 3);
            @(negedge clk);
            chk($sformatf("pause_af1_c%0d", i), push_pause, (i >= 2 && i <= 4));
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            fifo0_almost_full = (i == 1);
            @(negedge clk);
            chk($sformatf("pause_af0_c%0d", i), push_pause, (i == 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
- Sits after the class demultiplexer, which steers 10-bit words by tag bits [9:8] into FIFO0 (tag 2'b00) and FIFO1 (tag 2'b10).
- Drains both FIFOs into one egress lane using weighted round-robin.
- Re-attaches the class tag to each 8-bit payload.
- Generates a push-pause back to the upstream source when either FIFO nears full.

Parameters:
- DATA_SIZE, 10, egress word width; equals MAIN_SIZE+2.
- MAIN_SIZE, 8, FIFO payload width.
- WEIGHT0, 3, maximum consecutive grants to FIFO0 per turn (1..15).
- WEIGHT1, 1, maximum consecutive grants to FIFO1 per turn (1..15).

Ports:
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- fifo0_empty  in  1  FIFO0 empty flag; reflects a pop at the following edge.
- fifo1_empty  in  1  FIFO1 empty flag; same timing as fifo0_empty.
- fifo0_almost_full  in  1  FIFO0 almost-full flag.
- fifo1_almost_full  in  1  FIFO1 almost-full flag.
- fifo0_data  in  MAIN_SIZE  FIFO0 read data; valid one cycle after pop0.
- fifo1_data  in  MAIN_SIZE  FIFO1 read data; valid one cycle after pop1.
- dest_ready  in  1  downstream space flag; guarantees at least 2 free slots while high.
- pop0  out  1  read strobe to FIFO0.
- pop1  out  1  read strobe to FIFO1.
- data_out  out  DATA_SIZE  {tag[1:0], payload}.
- valid_out  out  1  data_out qualifier.
- push_pause  out  1  stall request to the upstream source.
- grant_id  out  1  currently served FIFO (0/1), for debug.

Behaviour:
- Reset (synchronous, sampled on the clk rising edge):
  - state=IDLE, rr_ptr=0, cnt=0.
  - valid_out=0, data_out=0, push_pause=0, grant_id=0.
  - Both in-flight pipeline stages are cleared.
  - pop0=pop1=0 while reset is high.
  - Reset asserted mid-operation drops in-flight words; valid_out is 0 in the cycle after the reset edge.
- States: IDLE, SERVE0, SERVE1. Registers: cnt (4 bits), rr_ptr (which FIFO is preferred next).
- Pop generation (combinational from state and inputs):
  - pop0 = (state==SERVE0) & ~fifo0_empty & dest_ready.
  - pop1 is the same with SERVE1 and FIFO1.
  - pop0 and pop1 are never high together.
- Transitions from IDLE:
  - Both FIFOs empty: stay in IDLE.
  - Only one FIFO non-empty: go to that FIFO's SERVE state.
  - Both non-empty: go to SERVEx with x=rr_ptr.
  - cnt is cleared on entering a SERVE state.
- Transitions from SERVEx:
  - Each pop increments cnt.
  - Leave when cnt reaches WEIGHTx-1 with a pop in the same cycle, or when FIFO x is empty.
  - On leaving: rr_ptr = other FIFO; go to SERVE(other) if it is non-empty, otherwise IDLE.
  - dest_ready low: hold state and cnt; no pop.
- Datapath:
  - A pop in cycle N makes FIFO data valid in N+1.
  - The arbiter registers it: valid_out=1 and data_out={tag,payload} in N+2.
  - Tag is 2'b00 for FIFO0 and 2'b10 for FIFO1.
  - Latency is 2 cycles, throughput is 1 word per cycle, and back-to-back pops are allowed.
- push_pause is registered:
  - Set in the cycle after either almost_full is high.
  - Cleared in the cycle after both are low.
  - Independent of the arbiter state.
- grant_id is registered: 0 in SERVE0 and IDLE, 1 in SERVE1.
- Boundary conditions:
  - Pop on the last word: empty rises next cycle, so there is no further pop; the state changes that cycle.
  - WEIGHT=1 alternates every word when both FIFOs have data.
  - dest_ready drop: at most 2 already-popped words still emerge on valid_out.

Decomposition:
- Shared package holds:
  - State encodings IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2.
  - Tag constants TAG_FIFO0=2'b00, TAG_FIFO1=2'b10.
  - MAIN_SIZE and DATA_SIZE defaults.
- One sub-module, wrr_grant_counter: the cnt/weight compare, which outputs turn_done for SERVEx.

Test Plan:
- Reset: hold reset for 3 cycles with both FIFOs holding data -> pop0=pop1=0, valid_out=0, push_pause=0 throughout.
- Weighted service:
  - Stimulus: FIFO0 holds 0xFF,0xEE,0xAA,0xBB; FIFO1 holds 0xDD,0xCC; dest_ready=1.
  - Required egress: 0x0FF,0x0EE,0x0AA,0x2DD,0x0BB,0x2CC, one word per cycle.
  - The first valid_out is 2 cycles after the first pop.
- Single source: only FIFO1 holds 0x99,0x88,0x77 -> output 0x299,0x288,0x277 back-to-back; state returns to IDLE after 0x77.
- Backpressure:
  - Stimulus: dest_ready drops for 4 cycles mid-stream.
  - Required: no pops while low; at most 2 words emerge; on recovery cnt resumes with no loss or duplication.
- Pause: fifo1_almost_full pulses high for 3 cycles -> push_pause high for exactly 3 cycles, delayed by 1 cycle.
- Mid-stream reset: reset asserted during SERVE0 with 2 words in flight -> valid_out=0 next cycle; after release, serving restarts from FIFO0 with rr_ptr=0.
